// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiply sequencer that borrows the shared 8-bit ALU, one multiplier bit per cycle.
// Optional feature macro: MUL_EARLY_EXIT_EN (finish as soon as the remaining multiplier bits are all zero).
module alu_mul_seq #(
    parameter int BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  mcand,
    input  logic [7:0]  mplier,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry
);

    localparam logic [3:0] kCLEAR  = 4'h0;
    localparam logic [3:0] kPASS_A = 4'h1;
    localparam logic [3:0] kADD    = 4'h2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] BITS_L     = 4'(BITS);
    localparam logic [4:0] SHIFT_BASE = 5'(8 - BITS);

    generate
        if (BITS < 1 || BITS > 8) begin : g_bits_range
            $error("alu_mul_seq: BITS must be in 1..8");
        end
    endgenerate

    logic [1:0]  state_r;
    logic [7:0]  hi_r;
    logic [7:0]  lo_r;
    logic [7:0]  mc_r;
    logic [3:0]  cnt_r;
    logic [15:0] product_r;

    logic [8:0]  sum_s;
    logic [7:0]  hi_next_s;
    logic [7:0]  lo_next_s;
    logic [3:0]  cnt_next_s;
    logic [15:0] full_s;
    logic [4:0]  shift_s;
    logic        early_s;

    // ALU drive: add when the current multiplier bit is set, otherwise pass the accumulator through.
    always_comb begin
        alu_op = kCLEAR;
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        sum_s  = 9'h000;
        if (state_r == ST_STEP) begin
            alu_a = hi_r;
            alu_b = mc_r;
            if (lo_r[0]) begin
                alu_op = kADD;
                sum_s  = {alu_carry, alu_out};
            end else begin
                alu_op = kPASS_A;
                sum_s  = {1'b0, alu_out};
            end
        end else begin
            alu_op = kCLEAR;
        end
    end

    assign hi_next_s  = sum_s[8:1];
    assign lo_next_s  = {sum_s[0], lo_r[7:1]};
    assign cnt_next_s = cnt_r - 4'd1;
    assign full_s     = {hi_next_s, lo_next_s};
    // Skipped zero bits would only shift right, so one shift covers both normal and early completion.
    assign shift_s    = SHIFT_BASE + {1'b0, cnt_next_s};

`ifdef MUL_EARLY_EXIT_EN
    logic [8:0] rem_mask_s;
    assign rem_mask_s = (9'd1 << cnt_next_s) - 9'd1;
    assign early_s    = ((({1'b0, lo_next_s}) & rem_mask_s) == 9'd0) && (cnt_next_s != 4'd0);
`else
    assign early_s    = 1'b0;
`endif

    // Sequencer state, partial product registers and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            hi_r      <= 8'h00;
            lo_r      <= 8'h00;
            mc_r      <= 8'h00;
            cnt_r     <= 4'd0;
            product_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mc_r    <= mcand;
                        hi_r    <= 8'h00;
                        lo_r    <= mplier;
                        cnt_r   <= BITS_L;
                        state_r <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    hi_r  <= hi_next_s;
                    lo_r  <= lo_next_s;
                    cnt_r <= cnt_next_s;
                    if (cnt_r == 4'd1 || early_s) begin
                        product_r <= full_s >> shift_s;
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_STEP);
    assign product   = product_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: BITS=8 and BITS=4 instances, each with a behavioural ALU.
module tb_alu_mul_seq;

    localparam logic [3:0] K_CLEAR  = 4'h0;
    localparam logic [3:0] K_PASS_A = 4'h1;
    localparam logic [3:0] K_ADD    = 4'h2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid8, out_ready8, in_ready8, out_valid8, busy8, alu_carry8;
    logic [7:0]  mcand8, mplier8, alu_a8, alu_b8, alu_out8;
    logic [3:0]  alu_op8;
    logic [15:0] product8;

    logic        in_valid4, out_ready4, in_ready4, out_valid4, busy4, alu_carry4;
    logic [7:0]  mcand4, mplier4, alu_a4, alu_b4, alu_out4;
    logic [3:0]  alu_op4;
    logic [15:0] product4;

    alu_mul_seq #(.BITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .mcand(mcand8), .mplier(mplier8), .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8), .alu_op(alu_op8), .alu_a(alu_a8), .alu_b(alu_b8),
        .alu_out(alu_out8), .alu_carry(alu_carry8)
    );

    alu_mul_seq #(.BITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .mcand(mcand4), .mplier(mplier4), .out_valid(out_valid4), .out_ready(out_ready4),
        .product(product4), .busy(busy4), .alu_op(alu_op4), .alu_a(alu_a4), .alu_b(alu_b4),
        .alu_out(alu_out4), .alu_carry(alu_carry4)
    );

    // Shared 8-bit ALU models
    always_comb begin
        case (alu_op8)
            K_ADD:    {alu_carry8, alu_out8} = {1'b0, alu_a8} + {1'b0, alu_b8};
            K_PASS_A: {alu_carry8, alu_out8} = {1'b0, alu_a8};
            default:  {alu_carry8, alu_out8} = 9'h000;
        endcase
    end

    always_comb begin
        case (alu_op4)
            K_ADD:    {alu_carry4, alu_out4} = {1'b0, alu_a4} + {1'b0, alu_b4};
            K_PASS_A: {alu_carry4, alu_out4} = {1'b0, alu_a4};
            default:  {alu_carry4, alu_out4} = 9'h000;
        endcase
    end

    logic        sel;
    logic        in_ready_x, out_valid_x, busy_x;
    logic [3:0]  alu_op_x;
    logic [7:0]  alu_a_x, alu_b_x;
    logic [15:0] product_x;

    always_comb begin
        in_ready_x  = sel ? in_ready4  : in_ready8;
        out_valid_x = sel ? out_valid4 : out_valid8;
        busy_x      = sel ? busy4      : busy8;
        alu_op_x    = sel ? alu_op4    : alu_op8;
        alu_a_x     = sel ? alu_a4     : alu_a8;
        alu_b_x     = sel ? alu_b4     : alu_b8;
        product_x   = sel ? product4   : product8;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            in_valid4 = v; mcand4 = a; mplier4 = b;
        end else begin
            in_valid8 = v; mcand8 = a; mplier8 = b;
        end
    endtask

    task automatic set_ready(input logic r);
        if (sel) out_ready4 = r;
        else     out_ready8 = r;
    endtask

    // One full transaction: accept, step, wait with out_ready low for 'hold' cycles, consume.
    task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input logic noise);
        int bits;
        int expected;
        int cycles;
        logic [15:0] held;
        sel      = s;
        bits     = s ? 4 : 8;
        expected = int'(a) * (int'(b) % (1 << bits));
        @(negedge clk);
        check("in_ready_idle", in_ready_x, 1'b1);
        set_in(1'b1, a, b);
        @(posedge clk); #1;
        set_in(1'b0, 8'($urandom), 8'($urandom));
        cycles = 0;
        while (!out_valid_x && cycles < 40) begin
            check("busy_step", busy_x, 1'b1);
            check("in_ready_step", in_ready_x, 1'b0);
            check("alu_op_step", alu_op_x, (((int'(b) >> cycles) & 1) == 1) ? K_ADD : K_PASS_A);
            check("alu_b_step", alu_b_x, a);
            if (noise) set_in(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            @(posedge clk); #1;
            cycles++;
        end
        set_in(1'b0, 8'h00, 8'h00);
        check("latency", cycles, bits);
        check("product", product_x, expected);
        check("busy_done", busy_x, 1'b0);
        check("in_ready_done", in_ready_x, 1'b0);
        held = product_x;
        for (int i = 0; i < hold; i++) begin
            set_in(1'b1, 8'($urandom), 8'($urandom));
            check("hold_valid", out_valid_x, 1'b1);
            check("hold_product", product_x, held);
            check("hold_in_ready", in_ready_x, 1'b0);
            check("hold_alu_op", alu_op_x, K_CLEAR);
            @(posedge clk); #1;
        end
        set_ready(1'b1);
        @(posedge clk); #1;
        set_ready(1'b0);
        set_in(1'b0, 8'h00, 8'h00);
        check("consumed_valid", out_valid_x, 1'b0);
        check("back_idle", in_ready_x, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; mcand8 = 8'h00; mplier8 = 8'h00;
        in_valid4 = 1'b0; out_ready4 = 1'b0; mcand4 = 8'h00; mplier4 = 8'h00;
        sel = 1'b0;
        #12;
        check("rst_in_ready8", in_ready8, 1'b1);
        check("rst_out_valid8", out_valid8, 1'b0);
        check("rst_busy8", busy8, 1'b0);
        check("rst_product8", product8, 16'h0000);
        check("rst_alu_op8", alu_op8, K_CLEAR);
        check("rst_in_ready4", in_ready4, 1'b1);
        check("rst_product4", product4, 16'h0000);
        rst_n = 1'b1;

        run_op(1'b0, 8'd13, 8'd11, 0, 1'b0);    // 143
        run_op(1'b0, 8'd255, 8'd255, 0, 1'b0);  // 65025, kADD every step
        run_op(1'b0, 8'd0, 8'd200, 0, 1'b0);
        run_op(1'b0, 8'd77, 8'd0, 0, 1'b0);
        run_op(1'b0, 8'd90, 8'd170, 5, 1'b0);
        run_op(1'b1, 8'd200, 8'hF3, 0, 1'b0);   // 600
        run_op(1'b1, 8'd200, 8'h01, 2, 1'b0);

        // Reset in the 4th STEP cycle aborts the operation
        sel = 1'b0;
        @(negedge clk);
        set_in(1'b1, 8'd100, 8'd200);
        @(posedge clk); #1;
        set_in(1'b0, 8'h00, 8'h00);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready8, 1'b1);
        check("abort_out_valid", out_valid8, 1'b0);
        check("abort_busy", busy8, 1'b0);
        check("abort_alu_op", alu_op8, K_CLEAR);
        check("abort_product", product8, 16'h0000);
        #3;
        rst_n = 1'b1;
        run_op(1'b0, 8'd6, 8'd7, 0, 1'b0);      // 42

        for (int k = 0; k < 6; k++) begin
            run_op(1'b0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b1);
            run_op(1'b1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
